vga_frame_decimator: RTL and testbench
======================================

Name: vga_frame_decimator

Overview:
- Sits directly downstream of the VGA sync generator, in the VGA_CLK domain.
- Consumes its registered DE/HS/VS and the pixel word aligned to DE.
- Decimates the active area by integer factors and writes the result into the LED-matrix frame buffer through a small elastic FIFO with a valid/ready write port.
- Reports frame completion and sticky overflow.

Parameters:
- ACT_W, 640, active pixels per line.
- ACT_H, 480, active lines per frame.
- DEC_X, 10, horizontal decimation factor; OUT_W = ACT_W/DEC_X, exact division required.
- DEC_Y, 10, vertical decimation factor; OUT_H = ACT_H/DEC_Y, exact division required.
- PIX_W, 24, pixel word width.
- ADDR_W, 12, write address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2 and at least 2.

Ports:
- VGA_CLK  in  1  pixel clock.
- RESET  in  1  asynchronous, active-high reset.
- DE  in  1  active-video enable from the sync generator.
- HS  in  1  horizontal sync, active-high; monitored only.
- VS  in  1  vertical sync, active-high.
- PIX  in  PIX_W  pixel, valid in the cycles where DE=1.
- ENABLE  in  1  capture enable, sampled at frame start.
- WR_READY  in  1  frame buffer accepts a write this cycle.
- WR_VALID  out  1  write request.
- WR_ADDR  out  ADDR_W  linear buffer address, oy*OUT_W+ox.
- WR_DATA  out  PIX_W  decimated pixel.
- FRAME_DONE  out  1  one-cycle pulse when the last sample of a frame has been written.
- OVERFLOW  out  1  sticky flag: a sample was dropped.
- OVF_CLR  in  1  synchronous clear of OVERFLOW.

Behaviour:
- Reset (async, RESET=1):
  - All outputs are 0.
  - FIFO is empty.
  - Every counter is 0.
  - FSM is in IDLE.
- Edge detection: VS and DE are registered once internally.
  - vs_rise = VS & ~VS_q.
  - de_fall = ~DE & DE_q.
- Line position:
  - x counts DE=1 cycles and clears on de_fall.
  - Cycles with x >= ACT_W are ignored.
- Line count:
  - y increments on de_fall and clears on vs_rise.
  - Lines with y >= ACT_H are ignored.
- Phase counters:
  - px wraps 0..DEC_X-1 with x; py wraps 0..DEC_Y-1 with y.
  - Both clear on vs_rise; px also clears on de_fall.
  - No divider or modulo operators.
- Sample condition: state CAPTURE, DE=1, px=0, py=0, x<ACT_W, y<ACT_H.
- On a sample, {addr, PIX} is pushed into the FIFO, then addr increments.
  - addr clears on vs_rise.
  - addr increments whether or not the push succeeded, so later samples keep correct addresses.
- FIFO:
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and OVERFLOW is set next cycle.
  - If set and OVF_CLR occur in the same cycle, set wins.
- Write port:
  - WR_VALID = FIFO not empty.
  - WR_ADDR/WR_DATA show the FIFO head and are held stable while WR_VALID=1 and WR_READY=0.
  - Pop occurs on WR_VALID & WR_READY.
  - Latency: a sample taken in cycle n is presented at the earliest in cycle n+1.
- FSM:
  - IDLE: on vs_rise with ENABLE=1, go to CAPTURE and clear counters; with ENABLE=0, stay in IDLE.
  - CAPTURE: after the push attempt for addr = OUT_W*OUT_H-1, go to DRAIN.
  - CAPTURE, vs_rise before the last sample (short frame): counters restart. Go to CAPTURE if ENABLE=1, else IDLE. FIFO is not flushed. No FRAME_DONE.
  - DRAIN: when the FIFO becomes empty (last pop), pulse FRAME_DONE for 1 cycle and go to IDLE.
  - DRAIN: vs_rise is ignored, so that frame is skipped.
- ENABLE changes mid-frame have no effect until the next vs_rise.
- HS does not affect behaviour.

Test Plan:
- Use ACT_W=8, ACT_H=4, DEC_X=2, DEC_Y=2, WR_READY=1, ENABLE=1, PIX=y*16+x. Drive one frame.
  - Required: exactly 8 writes.
  - Addresses 0..7 with data 0x00, 0x02, 0x04, 0x06, 0x20, 0x22, 0x24, 0x26.
  - FRAME_DONE pulses once, after the write to address 7.
  - OVERFLOW stays 0.
- Same setup with WR_READY=0 for the whole first active line, FIFO_DEPTH=2.
  - Required: samples 2 and 3 are dropped and OVERFLOW=1.
  - Write addresses observed are 0, 1, 4, 5, 6, 7, so addresses do not shift.
- WR_READY toggling 1/0 each cycle.
  - Required: WR_ADDR/WR_DATA are held while stalled.
  - No duplicate or missing address 0..7.
- ENABLE=0 at vs_rise, then raised mid-frame.
  - Required: no WR_VALID that frame; capture starts on the next frame.
- Assert RESET during CAPTURE with 2 entries in the FIFO.
  - Required: WR_VALID and all other outputs are 0 immediately.
  - After release, nothing happens until the next vs_rise with ENABLE=1, then the frame is captured normally.
- vs_rise after 2 lines (short frame), then a full frame.
  - Required: no FRAME_DONE for the short frame.
  - The full frame restarts at address 0 and ends with one FRAME_DONE.
  - OVF_CLR with no drop active clears OVERFLOW.

Source files
------------

// File: rtl/vga_frame_decimator_if.sv
// ============================================================================
//  Module   : vga_frame_decimator_if
//  Brief    : Valid/ready write port from the decimator into the frame buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface vga_frame_decimator_if #(
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 24
);
    logic              WR_VALID;
    logic              WR_READY;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [PIX_W-1:0]  WR_DATA;

    modport master (output WR_VALID, output WR_ADDR, output WR_DATA, input  WR_READY);
    modport slave  (input  WR_VALID, input  WR_ADDR, input  WR_DATA, output WR_READY);
endinterface

`default_nettype wire

// File: rtl/vga_frame_decimator.sv
// ============================================================================
//  Module   : vga_frame_decimator
//  Brief    : Decimates the VGA active area and streams samples into the
//             LED-matrix frame buffer through a small elastic FIFO.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vga_frame_decimator #(
    parameter int ACT_W      = 640,
    parameter int ACT_H      = 480,
    parameter int DEC_X      = 10,
    parameter int DEC_Y      = 10,
    parameter int PIX_W      = 24,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  VGA_CLK,
    input  logic                  RESET,
    input  logic                  DE,
    input  logic                  HS,
    input  logic                  VS,
    input  logic [PIX_W-1:0]      PIX,
    input  logic                  ENABLE,
    input  logic                  OVF_CLR,
    output logic                  FRAME_DONE,
    output logic                  OVERFLOW,
    vga_frame_decimator_if.master wr
);
    localparam int c_OUT_W  = ACT_W / DEC_X;
    localparam int c_OUT_H  = ACT_H / DEC_Y;
    localparam int c_LAST   = c_OUT_W * c_OUT_H - 1;
    localparam int c_X_W    = $clog2(ACT_W + 1);
    localparam int c_Y_W    = $clog2(ACT_H + 1);
    localparam int c_PX_W   = (DEC_X > 1) ? $clog2(DEC_X) : 1;
    localparam int c_PY_W   = (DEC_Y > 1) ? $clog2(DEC_Y) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_ENT_W  = ADDR_W + PIX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_vs_q, r_de_q;
    logic [c_X_W-1:0]    r_x;
    logic [c_Y_W-1:0]    r_y;
    logic [c_PX_W-1:0]   r_px;
    logic [c_PY_W-1:0]   r_py;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_frame_done, r_overflow;
    logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // HS carries no information this block needs.
    wire w_unused_hs = HS;

    wire w_vs_rise = VS & ~r_vs_q;
    wire w_de_fall = ~DE & r_de_q;
    wire w_x_in    = r_x < c_X_W'(ACT_W);
    wire w_y_in    = r_y < c_Y_W'(ACT_H);
    wire w_sample  = (r_state == S_CAPTURE) & DE & (r_px == '0) & (r_py == '0) & w_x_in & w_y_in;
    wire w_valid   = (r_count != '0);
    wire w_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
    wire w_pop     = w_valid & wr.WR_READY;
    wire w_push    = w_sample & (~w_full | w_pop);
    wire w_drop    = w_sample & ~w_push;
    wire [c_ENT_W-1:0] w_head = r_mem[r_rd_ptr];

    assign wr.WR_VALID = w_valid;
    assign wr.WR_ADDR  = w_valid ? w_head[c_ENT_W-1:PIX_W] : '0;
    assign wr.WR_DATA  = w_valid ? w_head[PIX_W-1:0]       : '0;
    assign FRAME_DONE  = r_frame_done;
    assign OVERFLOW    = r_overflow;

    // Raster position and decimation phase; phases wrap instead of dividing.
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            r_vs_q <= 1'b0;
            r_de_q <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_px   <= '0;
            r_py   <= '0;
        end else begin
            r_vs_q <= VS;
            r_de_q <= DE;
            if (w_vs_rise) begin
                r_x  <= '0;
                r_px <= '0;
                r_y  <= '0;
                r_py <= '0;
            end else if (w_de_fall) begin
                r_x  <= '0;
                r_px <= '0;
                if (w_y_in) begin
                    r_y  <= r_y + 1'b1;
                    r_py <= (r_py == c_PY_W'(DEC_Y - 1)) ? '0 : r_py + 1'b1;
                end
            end else if (DE && w_x_in) begin
                r_x  <= r_x + 1'b1;
                r_px <= (r_px == c_PX_W'(DEC_X - 1)) ? '0 : r_px + 1'b1;
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_addr, PIX};
        end
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Address advances on every sample, pushed or dropped, so later pixels land correctly.
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_drop)       r_overflow <= 1'b1;
            else if (OVF_CLR) r_overflow <= 1'b0;

            if (w_vs_rise)     r_addr <= '0;
            else if (w_sample) r_addr <= r_addr + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_vs_rise && ENABLE) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_vs_rise)
                        r_state <= ENABLE ? S_CAPTURE : S_IDLE;
                    else if (w_sample && (r_addr == ADDR_W'(c_LAST)))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((r_count == '0) || (w_pop && (r_count == c_CNT_W'(1)))) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_vga_frame_decimator.sv
// ============================================================================
//  Module   : tb_vga_frame_decimator
//  Brief    : Self-checking bench for vga_frame_decimator on a small 8x4 raster.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_frame_decimator;
    localparam int ACT_W = 8, ACT_H = 4, DEC_X = 2, DEC_Y = 2;
    localparam int OUT_W = ACT_W / DEC_X, OUT_H = ACT_H / DEC_Y, DEPTH = 2;
    localparam int M_IDLE = 0, M_CAPT = 1, M_DRAIN = 2;

    typedef struct packed {
        int          cyc;
        logic        done;
        logic [3:0]  a;
        logic [23:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic RESET, DE, HS, VS, ENABLE, OVF_CLR, FRAME_DONE, OVERFLOW;
    logic [23:0] PIX;

    vga_frame_decimator_if #(.ADDR_W(4), .PIX_W(24)) wr_if ();

    vga_frame_decimator #(
        .ACT_W(ACT_W), .ACT_H(ACT_H), .DEC_X(DEC_X), .DEC_Y(DEC_Y),
        .PIX_W(24), .ADDR_W(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .VGA_CLK(clk), .RESET(RESET), .DE(DE), .HS(HS), .VS(VS), .PIX(PIX),
        .ENABLE(ENABLE), .OVF_CLR(OVF_CLR), .FRAME_DONE(FRAME_DONE),
        .OVERFLOW(OVERFLOW), .wr(wr_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, rdy_mode = 0, stall_err = 0, valid_seen = 0;
    bit pix_rand = 0, prev_vs = 0, tb_vs_rise = 0;
    int tb_x = 0, tb_y = 0;
    ent_t act_log[$], exp_log[$], wq[$];

    // Reference: frame-level capture decision plus a FIFO kept as a queue.
    logic [27:0] mq[$];
    int  m_mode = M_IDLE;
    logic m_ovf = 1'b0;

    always @(posedge clk) begin
        logic [27:0] h;
        ent_t e;
        bit pop, drop, was_drain;
        int a;
        if (RESET) begin
            mq.delete();
            m_mode = M_IDLE;
            m_ovf  = 1'b0;
        end else begin
            was_drain = (m_mode == M_DRAIN);
            pop  = (mq.size() > 0) && wr_if.WR_READY;
            drop = 0;
            if (pop) begin
                h = mq.pop_front();
                e.cyc = cyc; e.done = 1'b0; e.a = h[27:24]; e.d = h[23:0];
                exp_log.push_back(e);
            end
            if (tb_vs_rise && !was_drain) begin
                m_mode = ENABLE ? M_CAPT : M_IDLE;
            end else if (m_mode == M_CAPT && DE && tb_x < ACT_W && tb_y < ACT_H &&
                         tb_x % DEC_X == 0 && tb_y % DEC_Y == 0) begin
                a = (tb_y / DEC_Y) * OUT_W + tb_x / DEC_X;
                if (mq.size() < DEPTH) mq.push_back({4'(a), PIX});
                else drop = 1;
                if (a == OUT_W * OUT_H - 1) m_mode = M_DRAIN;
            end
            if (was_drain && mq.size() == 0) begin
                e.cyc = cyc + 1; e.done = 1'b1; e.a = 4'd0; e.d = 24'd0;
                exp_log.push_back(e);
                m_mode = M_IDLE;
            end
            if (drop) m_ovf = 1'b1;
            else if (OVF_CLR) m_ovf = 1'b0;
        end
        cyc++;
    end

    logic p_valid = 1'b0, p_ready = 1'b0;
    logic [3:0] p_a = '0;
    logic [23:0] p_d = '0;

    always @(negedge clk) begin
        ent_t e;
        if (!RESET) begin
            if (p_valid && !p_ready && wr_if.WR_VALID &&
                (wr_if.WR_ADDR !== p_a || wr_if.WR_DATA !== p_d)) stall_err++;
            if (wr_if.WR_VALID) valid_seen++;
            if (wr_if.WR_VALID && wr_if.WR_READY) begin
                e.cyc = cyc; e.done = 1'b0; e.a = wr_if.WR_ADDR; e.d = wr_if.WR_DATA;
                act_log.push_back(e);
            end
            if (FRAME_DONE) begin
                e.cyc = cyc; e.done = 1'b1; e.a = 4'd0; e.d = 24'd0;
                act_log.push_back(e);
            end
        end
        p_valid = RESET ? 1'b0 : wr_if.WR_VALID;
        p_ready = wr_if.WR_READY;
        p_a     = wr_if.WR_ADDR;
        p_d     = wr_if.WR_DATA;
    end

    function automatic int log_diff();
        int n = 0;
        int m = (act_log.size() < exp_log.size()) ? act_log.size() : exp_log.size();
        for (int i = 0; i < m; i++) if (act_log[i] !== exp_log[i]) n++;
        n += (act_log.size() > exp_log.size()) ? act_log.size() - exp_log.size()
                                               : exp_log.size() - act_log.size();
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (act_log[i]) if (act_log[i].done) n++;
        return n;
    endfunction

    task automatic get_writes();
        wq.delete();
        foreach (act_log[i]) if (!act_log[i].done) wq.push_back(act_log[i]);
    endtask

    task automatic clear_logs();
        act_log.delete();
        exp_log.delete();
        stall_err  = 0;
        valid_seen = 0;
    endtask

    task automatic drive(input logic de, input logic vs, input int x, input int y);
        DE = de; VS = vs; tb_x = x; tb_y = y;
        HS = (!de && !vs) ? 1'($urandom_range(0, 1)) : 1'b0;
        tb_vs_rise = vs && !prev_vs;
        prev_vs = vs;
        PIX = (de && !pix_rand) ? 24'(y * 16 + x) : 24'($urandom);
        case (rdy_mode)
            0:       wr_if.WR_READY = 1'b1;
            1:       wr_if.WR_READY = !(de && y == 0);
            2:       wr_if.WR_READY = ~wr_if.WR_READY;
            default: wr_if.WR_READY = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input int lines, input int de_len, input int en_line, input int tail);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        for (int y = 0; y < lines; y++) begin
            if (y == en_line) ENABLE = 1'b1;
            for (int x = 0; x < de_len; x++) drive(1, 0, x, y);
            repeat (4) drive(0, 0, 0, y);
        end
        repeat (tail) drive(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        n_checks++; if (wr_if.WR_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", wr_if.WR_VALID); end
        n_checks++; if (wr_if.WR_ADDR !== 4'd0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", wr_if.WR_ADDR); end
        n_checks++; if (wr_if.WR_DATA !== 24'd0) begin n_errors++; $display("FAIL reset_data: got %h want 0", wr_if.WR_DATA); end
        n_checks++; if (FRAME_DONE !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", FRAME_DONE); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
        RESET = 1'b0;
        repeat (3) drive(0, 0, 0, 0);
    endtask

    task automatic test_basic();
        logic [23:0] exp_d [8] = '{24'h00, 24'h02, 24'h04, 24'h06, 24'h20, 24'h22, 24'h24, 24'h26};
        clear_logs(); ENABLE = 1'b1; rdy_mode = 0; pix_rand = 0;
        frame(4, ACT_W, -1, 12);
        get_writes();
        n_checks++; if (wq.size() !== 8) begin n_errors++; $display("FAIL basic_count: got %0d want 8", wq.size()); end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].a !== 4'(i) || wq[i].d !== exp_d[i]) begin
                n_errors++;
                $display("FAIL basic_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i, wq[i].a, wq[i].d, i, exp_d[i]);
            end
        end
        n_checks++; if (count_done() !== 1) begin n_errors++; $display("FAIL basic_done_count: got %0d want 1", count_done()); end
        n_checks++;
        if (act_log.size() < 2 || act_log[act_log.size()-1].done !== 1'b1 || act_log[act_log.size()-2].a !== 4'd7) begin
            n_errors++; $display("FAIL basic_done_order: done not right after write to address 7 (log size %0d)", act_log.size());
        end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b want 0", OVERFLOW); end
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL basic_model: %0d differing entries want 0", log_diff()); end
    endtask

    task automatic test_overflow();
        logic [3:0]  exp_a [6] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7};
        logic [23:0] exp_d [6] = '{24'h00, 24'h02, 24'h20, 24'h22, 24'h24, 24'h26};
        clear_logs(); rdy_mode = 1;
        frame(4, ACT_W, -1, 12);
        get_writes();
        n_checks++; if (wq.size() !== 6) begin n_errors++; $display("FAIL ovf_count: got %0d want 6", wq.size()); end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i].a !== exp_a[i] || wq[i].d !== exp_d[i]) begin
                n_errors++;
                $display("FAIL ovf_write[%0d]: got a=%0d d=%h want a=%0d d=%h", i, wq[i].a, wq[i].d, exp_a[i], exp_d[i]);
            end
        end
        n_checks++; if (OVERFLOW !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL ovf_model: %0d differing entries want 0", log_diff()); end
        rdy_mode = 0;
        OVF_CLR = 1'b1; drive(0, 0, 0, 0); OVF_CLR = 1'b0;
        n_checks++; if (OVERFLOW !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", OVERFLOW); end
    endtask

    task automatic test_toggle();
        int seen [8];
        clear_logs(); rdy_mode = 2;
        frame(4, ACT_W, -1, 16);
        get_writes();
        foreach (seen[i]) seen[i] = 0;
        foreach (wq[i]) if (wq[i].a < 8) seen[wq[i].a]++;
        n_checks++; if (stall_err !== 0) begin n_errors++; $display("FAIL toggle_hold: %0d changes while stalled want 0", stall_err); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (seen[i] !== 1) begin n_errors++; $display("FAIL toggle_addr[%0d]: seen %0d times want 1", i, seen[i]); end
        end
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL toggle_model: %0d differing entries want 0", log_diff()); end
    endtask

    task automatic test_enable();
        clear_logs(); rdy_mode = 0; ENABLE = 1'b0;
        frame(4, ACT_W, 1, 12);
        n_checks++; if (valid_seen !== 0) begin n_errors++; $display("FAIL enable_off_valid: %0d valid cycles want 0", valid_seen); end
        frame(4, ACT_W, -1, 12);
        get_writes();
        n_checks++; if (wq.size() !== 8) begin n_errors++; $display("FAIL enable_next_count: got %0d want 8", wq.size()); end
        n_checks++; if (count_done() !== 1) begin n_errors++; $display("FAIL enable_next_done: got %0d want 1", count_done()); end
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL enable_model: %0d differing entries want 0", log_diff()); end
    endtask

    task automatic test_reset_mid();
        clear_logs(); ENABLE = 1'b1; rdy_mode = 1;
        drive(0, 1, 0, 0); drive(0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
        for (int x = 0; x < 4; x++) drive(1, 0, x, 0);
        n_checks++; if (wr_if.WR_VALID !== 1'b1 || mq.size() !== 2) begin
            n_errors++; $display("FAIL rstmid_pre: valid=%b model_depth=%0d want 1 and 2", wr_if.WR_VALID, mq.size());
        end
        RESET = 1'b1;
        #1;
        n_checks++; if (wr_if.WR_VALID !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %b want 0", wr_if.WR_VALID); end
        n_checks++; if (wr_if.WR_ADDR !== 4'd0 || wr_if.WR_DATA !== 24'd0) begin
            n_errors++; $display("FAIL rstmid_bus: got a=%h d=%h want 0", wr_if.WR_ADDR, wr_if.WR_DATA);
        end
        n_checks++; if (FRAME_DONE !== 1'b0 || OVERFLOW !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_flags: got done=%b ovf=%b want 0", FRAME_DONE, OVERFLOW);
        end
        drive(1, 0, 4, 0); drive(1, 0, 5, 0);
        RESET = 1'b0;
        clear_logs();
        drive(1, 0, 6, 0); drive(1, 0, 7, 0);
        for (int y = 1; y < ACT_H; y++) begin
            repeat (4) drive(0, 0, 0, y - 1);
            for (int x = 0; x < ACT_W; x++) drive(1, 0, x, y);
        end
        repeat (6) drive(0, 0, 0, 0);
        n_checks++; if (valid_seen !== 0 || act_log.size() !== 0) begin
            n_errors++; $display("FAIL rstmid_quiet: %0d valid cycles %0d events want 0", valid_seen, act_log.size());
        end
        rdy_mode = 0;
        frame(4, ACT_W, -1, 12);
        get_writes();
        n_checks++; if (wq.size() !== 8 || count_done() !== 1) begin
            n_errors++; $display("FAIL rstmid_after: got %0d writes %0d done want 8 and 1", wq.size(), count_done());
        end
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL rstmid_model: %0d differing entries want 0", log_diff()); end
    endtask

    task automatic test_short();
        clear_logs(); ENABLE = 1'b1; rdy_mode = 0;
        frame(2, ACT_W, -1, 3);
        n_checks++; if (count_done() !== 0) begin n_errors++; $display("FAIL short_no_done: got %0d want 0", count_done()); end
        frame(4, ACT_W, -1, 12);
        get_writes();
        n_checks++; if (wq.size() !== 12) begin n_errors++; $display("FAIL short_count: got %0d want 12", wq.size()); end
        n_checks++; if (wq.size() > 4 && wq[4].a !== 4'd0) begin n_errors++; $display("FAIL short_restart: got a=%0d want 0", wq[4].a); end
        n_checks++; if (count_done() !== 1) begin n_errors++; $display("FAIL short_done: got %0d want 1", count_done()); end
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL short_model: %0d differing entries want 0", log_diff()); end
    endtask

    task automatic test_random();
        clear_logs(); pix_rand = 1; rdy_mode = 3;
        for (int f = 0; f < 8; f++) begin
            ENABLE = ($urandom_range(0, 3) != 0);
            frame($urandom_range(2, 5), $urandom_range(ACT_W, ACT_W + 2), -1, $urandom_range(0, 8));
            n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL random_frame[%0d]: %0d differing entries want 0", f, log_diff()); end
        end
        rdy_mode = 0; ENABLE = 1'b0;
        repeat (20) drive(0, 0, 0, 0);
        n_checks++; if (log_diff() !== 0) begin n_errors++; $display("FAIL random_final: %0d differing entries want 0", log_diff()); end
        n_checks++; if (OVERFLOW !== m_ovf) begin n_errors++; $display("FAIL random_ovf: got %b want %b", OVERFLOW, m_ovf); end
    endtask

    initial begin
        RESET = 1'b1; DE = 1'b0; HS = 1'b0; VS = 1'b0; ENABLE = 1'b0;
        OVF_CLR = 1'b0; PIX = '0; wr_if.WR_READY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_toggle();
        test_enable();
        test_reset_mid();
        test_short();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
